// File: rtl/lstm_acc_pkg.sv
// rtl/lstm_acc_pkg.sv - shared LSTM accelerator sizes and cell-buffer reader state type
//
// Purpose: common localparams for the LSTM accelerator datapath and the
//          state enumeration of the cell buffer read sequencer.
// Ports:   none (package).
package lstm_acc_pkg;

  localparam int ELEMENT_BITS = 8;  // width of one data element
  localparam int FEATURE_BITS = 4;  // cell DPR address width
  localparam int M            = 9;  // elements per pass
  localparam int P            = 4;  // PEs in the systolic array

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    DRAIN,
    DONE
  } rd_state_t;

endpackage

// File: rtl/cell_buffer_reader_pe_tick_gen.sv
// rtl/cell_buffer_reader_pe_tick_gen.sv - PE period divider for the cell buffer reader
//
// Purpose: divides sys_clk into PE periods of PE_DIV cycles. The count is
//          0 in the first cycle of a period and is forced back to 0 by reset
//          or by i_clear, so the cycle after a clear is always offset 0.
// Ports:
//   sys_clk         in   system clock
//   reset           in   synchronous reset, active-high
//   i_clear         in   restart the period count (accepted start)
//   o_period_start  out  high in the last cycle of a period: the next edge
//                        begins a new period
//   o_tick_offset2  out  high in offset-1 cycles: the next edge is the one
//                        at which PE(0) data updates (period start + 2)
module pe_tick_gen #(
  parameter int PE_DIV = 5
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_period_start,
  output logic o_tick_offset2
);

  localparam int CW = (PE_DIV > 1) ? $clog2(PE_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PE_DIV - 1);

  logic [CW-1:0] r_div_cnt;

  always_ff @(posedge sys_clk) begin
    if (reset || i_clear) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == LAST_CNT) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  assign o_period_start = (r_div_cnt == LAST_CNT);
  assign o_tick_offset2 = (r_div_cnt == CW'(1));

endmodule

// File: rtl/cell_buffer_reader.sv
// rtl/cell_buffer_reader.sv - reads the LSTM cell DPR and feeds PE(0) once per PE period
//
// Purpose: on start, reads M cell elements in address order from the cell
//          DPR, presents one per PE period on first_pe_data, then pushes
//          P-1 zero periods through the array and pulses done.
// Ports:
//   sys_clk                   in   system clock
//   reset                     in   synchronous reset, active-high
//   start                     in   one-cycle pulse, begins a pass (IDLE/DONE only)
//   cell_out_buffer_data_out  in   cell DPR read data, valid 1 cycle after cs/oe
//   address_read_cell         out  cell DPR read address (held while cs=0)
//   cs_read_cell              out  cell DPR chip select, read side
//   oe_read_cell              out  cell DPR output enable
//   first_pe_data             out  registered data to PE(0)
//   first_pe_valid            out  first_pe_data holds a real element
//   pe_tick                   out  high in the cycle first_pe_data updates
//   busy                      out  pass in progress
//   done                      out  one-cycle pulse at end of pass
module cell_buffer_reader #(
  parameter int ELEMENT_BITS = lstm_acc_pkg::ELEMENT_BITS,
  parameter int FEATURE_BITS = lstm_acc_pkg::FEATURE_BITS,
  parameter int M            = lstm_acc_pkg::M,
  parameter int P            = lstm_acc_pkg::P,
  parameter int PE_DIV       = 5
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ELEMENT_BITS-1:0] cell_out_buffer_data_out,
  output logic [FEATURE_BITS-1:0] address_read_cell,
  output logic                    cs_read_cell,
  output logic                    oe_read_cell,
  output logic [ELEMENT_BITS-1:0] first_pe_data,
  output logic                    first_pe_valid,
  output logic                    pe_tick,
  output logic                    busy,
  output logic                    done
);

  import lstm_acc_pkg::*;

  // Period index runs 0..M+P-2, so M+P-1 must be representable.
  localparam int KW = $clog2(M + P);
  localparam logic [KW-1:0] K_ELEM_END = KW'(M);          // first drain period
  localparam logic [KW-1:0] K_PASS_END = KW'(M + P - 1);  // period index of DONE

  rd_state_t               r_state;
  logic [KW-1:0]           r_elem_cnt;
  logic [FEATURE_BITS-1:0] r_addr;
  logic                    r_cs;
  logic [ELEMENT_BITS-1:0] r_data;
  logic                    r_valid;
  logic                    r_tick;
  logic                    r_busy;
  logic                    r_done;

  logic          w_accept;
  logic          w_period_start;
  logic          w_tick_offset2;
  logic [KW-1:0] w_next_k;

  // Start is honoured only between passes; DONE counts as between passes.
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_next_k = r_elem_cnt + KW'(1);

  pe_tick_gen #(
    .PE_DIV (PE_DIV)
  ) u_pe_tick_gen (
    .sys_clk        (sys_clk),
    .reset          (reset),
    .i_clear        (w_accept),
    .o_period_start (w_period_start),
    .o_tick_offset2 (w_tick_offset2)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_elem_cnt <= '0;
      r_addr     <= '0;
      r_cs       <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_tick     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // Strobes default low; each is raised for exactly one cycle below.
      r_cs   <= 1'b0;
      r_tick <= 1'b0;
      r_done <= 1'b0;

      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_state    <= FETCH;
            r_elem_cnt <= '0;
            r_addr     <= '0;
            r_cs       <= 1'b1;
            r_busy     <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end

        FETCH: r_state <= WAIT;

        // DPR data is on the bus during WAIT; capture it on the closing edge.
        WAIT: begin
          r_data  <= cell_out_buffer_data_out;
          r_valid <= 1'b1;
          r_tick  <= 1'b1;
          r_state <= HOLD;
        end

        HOLD, DRAIN: begin
          // Drain periods push a zero bubble at the same offset an element would land.
          if ((r_state == DRAIN) && w_tick_offset2) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_tick  <= 1'b1;
          end
          if (w_period_start) begin
            r_elem_cnt <= w_next_k;
            if (w_next_k < K_ELEM_END) begin
              r_state <= FETCH;
              r_cs    <= 1'b1;
              r_addr  <= r_addr + FEATURE_BITS'(1);
            end else if (w_next_k < K_PASS_END) begin
              r_state <= DRAIN;
            end else begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign address_read_cell = r_addr;
  assign cs_read_cell      = r_cs;
  assign oe_read_cell      = r_cs;
  assign first_pe_data     = r_data;
  assign first_pe_valid    = r_valid;
  assign pe_tick           = r_tick;
  assign busy              = r_busy;
  assign done              = r_done;

endmodule
